cpu_controller: RTL and testbench

Eight-phase instruction sequencer for the RISC CPU. It is the control end of the datapath that the ALU sits in. It drives the memory-address mux, read/write strobes, IR/PC/accumulator load enables and the data-bus enable. Inputs are the opcode held in the instruction register and the ALU zero flag. One instruction completes every eight clocks, and the block freezes on HLT.

---
 rtl/cpu_controller_pkg.sv | 30 +++
 rtl/cpu_controller_if.sv | 28 ++
 rtl/cpu_controller.sv | 90 +++++++++
 tb/tb_cpu_controller.sv | 136 +++++++++++++
 4 files changed

// File: rtl/cpu_controller_pkg.sv
// Shared opcode and phase encodings for the RISC CPU control path.
// Reused by the ALU, the decoder and the sequencer.
package cpu_controller_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  // Instructions that read an operand from memory and write the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Control bundle between the instruction sequencer and the datapath.
// master = sequencer side, slave = datapath side.
interface cpu_controller_if;

  logic [2:0] opcode;
  logic       zero;
  logic       sel;
  logic       rd;
  logic       wr;
  logic       ld_ir;
  logic       inc_pc;
  logic       ld_pc;
  logic       ld_ac;
  logic       data_e;
  logic       halt;
  logic [2:0] phase;

  modport master (
    input  opcode, zero,
    output sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt, phase
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt, phase
  );

endinterface

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer: one instruction per eight clocks,
// freezing in OP_FETCH once a HLT has been decoded.
//
// state      | meaning
// INST_ADDR  | PC drives memory address
// INST_FETCH | read instruction
// INST_LOAD  | load IR
// IDLE       | IR load held, opcode settles
// OP_ADDR    | IR address field drives memory, PC increments, HLT decoded
// OP_FETCH   | operand read (ALU ops); parking phase while halted
// ALU_OP     | ALU evaluates, SKZ/JMP/STO act
// STORE      | accumulator load, jump, or memory write
module cpu_controller
  import cpu_controller_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  cpu_controller_if.master bus
);

  phase_t phase_q;
  logic   halt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= INST_ADDR;
      halt_q  <= 1'b0;
    end else if (!halt_q) begin
      if (phase_q == OP_ADDR && bus.opcode == OP_HLT) begin
        halt_q  <= 1'b1;
        phase_q <= OP_FETCH;
      end else begin
        phase_q <= phase_t'(phase_q + 3'd1);
      end
    end
  end

  logic aluop, is_skz, is_jmp, is_sto;

  // Outputs stay combinational so an async reset reaches the strobes at once.
  always_comb begin
    aluop      = is_aluop(bus.opcode);
    is_skz     = (bus.opcode == OP_SKZ);
    is_jmp     = (bus.opcode == OP_JMP);
    is_sto     = (bus.opcode == OP_STO);
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.wr     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.data_e = 1'b0;
    if (!halt_q) begin
      case (phase_q)
        INST_ADDR: bus.sel = 1'b1;
        INST_FETCH: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        OP_ADDR: bus.inc_pc = 1'b1;
        OP_FETCH: bus.rd = aluop;
        ALU_OP: begin
          bus.rd     = aluop;
          bus.inc_pc = is_skz & bus.zero;
          bus.ld_pc  = is_jmp;
          bus.data_e = is_sto;
        end
        STORE: begin
          bus.rd     = aluop;
          bus.ld_ac  = aluop;
          bus.inc_pc = is_jmp;
          bus.ld_pc  = is_jmp;
          bus.wr     = is_sto;
          bus.data_e = is_sto;
        end
        default: ;
      endcase
    end
  end

  assign bus.halt  = halt_q;
  assign bus.phase = phase_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized self-checking bench for cpu_controller against a phase-mask
// reference model of the instruction sequence.
module tb_cpu_controller;

  logic clk = 1'b0;
  logic rst_n;

  cpu_controller_if bus ();

  cpu_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int         m_phase;
  logic       m_halt;
  logic [2:0] next_op;
  logic [2:0] op_at_edge;
  int         halt_cnt;
  bit         rst_test_done;
  logic [2:0] op_q[$];

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Each output is described by the set of phases in which it is high for
  // the given instruction; bit i of a mask is phase i.
  function automatic logic [8:0] model_out(input int ph, input logic [2:0] op,
                                            input logic z, input logic h);
    logic       alu, skz, jmp, sto;
    logic [7:0] m_sel, m_rd, m_wr, m_ldir, m_inc, m_ldpc, m_ldac, m_de;
    alu    = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    skz    = (op == 3'd1);
    jmp    = (op == 3'd7);
    sto    = (op == 3'd6);
    m_sel  = 8'b0000_1111;
    m_rd   = 8'b0000_1110 | (alu ? 8'b1110_0000 : 8'h00);
    m_ldir = 8'b0000_1100;
    m_inc  = 8'b0001_0000 | ((skz && z) ? 8'b0100_0000 : 8'h00) | (jmp ? 8'b1000_0000 : 8'h00);
    m_ldpc = jmp ? 8'b1100_0000 : 8'h00;
    m_ldac = alu ? 8'b1000_0000 : 8'h00;
    m_de   = sto ? 8'b1100_0000 : 8'h00;
    m_wr   = sto ? 8'b1000_0000 : 8'h00;
    if (h) return 9'b0_0000_0001;
    return {m_sel[ph], m_rd[ph], m_wr[ph], m_ldir[ph], m_inc[ph],
            m_ldpc[ph], m_ldac[ph], m_de[ph], 1'b0};
  endfunction

  task automatic compare_all(input string tag);
    logic [8:0] got;
    got = {bus.sel, bus.rd, bus.wr, bus.ld_ir, bus.inc_pc,
           bus.ld_pc, bus.ld_ac, bus.data_e, bus.halt};
    check_val($sformatf("%s_phase op=%0d", tag, bus.opcode), 16'(bus.phase), 16'(m_phase));
    check_val($sformatf("%s_outs ph=%0d op=%0d z=%0d", tag, m_phase, bus.opcode, bus.zero),
              16'(got), 16'(model_out(m_phase, bus.opcode, bus.zero, m_halt)));
  endtask

  // Asynchronous reset pulse placed mid-cycle, released before the next edge.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    m_phase  = 0;
    m_halt   = 1'b0;
    halt_cnt = 0;
    check_val({tag, "_wr"}, 16'(bus.wr), 16'd0);
    compare_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.opcode = 3'd0;
    bus.zero   = 1'b0;
    m_phase    = 0;
    m_halt     = 1'b0;
    halt_cnt   = 0;
    next_op    = 3'd0;
    rst_test_done = 1'b0;
    op_q = '{3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd7, 3'd6, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
    #1;
    compare_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_all("release");

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      op_at_edge = bus.opcode;
      #1;
      if (!m_halt) begin
        if (m_phase == 4 && op_at_edge == 3'd0) begin
          m_halt  = 1'b1;
          m_phase = 5;
        end else begin
          m_phase = (m_phase + 1) % 8;
        end
      end
      if (m_halt) halt_cnt++;
      if (m_phase == 1) begin
        if (op_q.size() > 0) next_op = op_q.pop_front();
        else if ($urandom_range(0, 15) == 0) next_op = 3'd0;
        else next_op = 3'($urandom_range(1, 7));
      end
      if (!m_halt && m_phase < 2) bus.opcode = 3'($urandom_range(0, 7));
      else bus.opcode = next_op;
      bus.zero = 1'($urandom_range(0, 1));
      #1;
      compare_all("run");
      if (!rst_test_done && !m_halt && m_phase == 7 && next_op == 3'd6) begin
        rst_test_done = 1'b1;
        pulse_reset("rst_mid_store");
      end else if (m_halt && halt_cnt >= 22) begin
        pulse_reset("rst_halt");
      end
    end

    check_val("rst_mid_store_reached", 16'(rst_test_done), 16'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
